// File: rtl/thermo_to_bin_pkg.sv
// Shared helpers for the thermometer-to-binary converter: clog2 and the default widths.
package thermo_to_bin_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  localparam int OSF_DFLT     = 8;
  localparam int SAMPLES_DFLT = 128;
  localparam int BW_DFLT      = clog2(OSF_DFLT + 1);
  localparam int SW_DFLT      = clog2(SAMPLES_DFLT * OSF_DFLT + 1);

endpackage

// File: rtl/thermo_to_bin_if.sv
// Sample input and result bus of the converter; master = front end/bench, slave = converter.
interface thermo_to_bin_if
  import thermo_to_bin_pkg::*;
#(
  parameter int OSF     = OSF_DFLT,
  parameter int SAMPLES = SAMPLES_DFLT
);
  localparam int BW = clog2(OSF + 1);
  localparam int SW = clog2(SAMPLES * OSF + 1);

  logic           in_valid;
  logic [OSF-1:0] thermo_in;
  logic [BW-1:0]  bin_out;
  logic           bin_valid;
  logic           bubble_err;
  logic [SW-1:0]  sum_out;
  logic           sum_valid;

  modport master (
    output in_valid, thermo_in,
    input  bin_out, bin_valid, bubble_err, sum_out, sum_valid
  );

  modport slave (
    input  in_valid, thermo_in,
    output bin_out, bin_valid, bubble_err, sum_out, sum_valid
  );
endinterface

// File: rtl/thermo_to_bin_popcount_tree.sv
// Combinational population count built as a recursive balanced adder tree.
module popcount_tree
  import thermo_to_bin_pkg::*;
#(
  parameter int WIDTH = OSF_DFLT
) (
  input  logic [WIDTH-1:0]               bits_i,
  output logic [clog2(WIDTH+1)-1:0]      cnt_o
);
  localparam int OW = clog2(WIDTH + 1);

  generate
    if (WIDTH == 1) begin : g_leaf
      assign cnt_o = bits_i;
    end else begin : g_split
      localparam int LO_W  = WIDTH / 2;
      localparam int HI_W  = WIDTH - LO_W;
      localparam int LO_OW = clog2(LO_W + 1);
      localparam int HI_OW = clog2(HI_W + 1);

      logic [LO_OW-1:0] lo_cnt;
      logic [HI_OW-1:0] hi_cnt;

      popcount_tree #(.WIDTH(LO_W)) u_lo (.bits_i(bits_i[LO_W-1:0]),     .cnt_o(lo_cnt));
      popcount_tree #(.WIDTH(HI_W)) u_hi (.bits_i(bits_i[WIDTH-1:LO_W]), .cnt_o(hi_cnt));

      assign cnt_o = OW'(lo_cnt) + OW'(hi_cnt);
    end
  endgenerate
endmodule

// File: rtl/thermo_to_bin.sv
// Thermometer-to-binary converter with bubble flag and per-frame sum; one sample per clock,
// results one cycle after acceptance, no backpressure.
module thermo_to_bin
  import thermo_to_bin_pkg::*;
#(
  parameter int SAMPLES = SAMPLES_DFLT,
  parameter int OSF     = OSF_DFLT
) (
  input  logic             clk,
  input  logic             rst,
  thermo_to_bin_if.slave   bus
);
  localparam int BW = clog2(OSF + 1);
  localparam int SW = clog2(SAMPLES * OSF + 1);
  localparam int CW = clog2(SAMPLES);

  logic [BW-1:0] cnt;
  logic          bubble;
  logic          frame_last;

  logic [BW-1:0] bin_q,     bin_d;
  logic          bub_q,     bub_d;
  logic          bin_vld_q, bin_vld_d;
  logic [SW-1:0] sum_q,     sum_d;
  logic          sum_vld_q, sum_vld_d;
  logic [SW-1:0] acc_q,     acc_d;
  logic [CW-1:0] smp_q,     smp_d;

  popcount_tree #(.WIDTH(OSF)) u_pop (.bits_i(bus.thermo_in), .cnt_o(cnt));

  // A clean code 2^k-1 plus one is a single bit just above the run, so the AND is zero.
  assign bubble     = |(bus.thermo_in & (bus.thermo_in + OSF'(1)));
  assign frame_last = (smp_q == CW'(SAMPLES - 1));

  always_comb begin
    bin_d     = bin_q;
    bub_d     = bub_q;
    bin_vld_d = 1'b0;
    sum_d     = sum_q;
    sum_vld_d = 1'b0;
    acc_d     = acc_q;
    smp_d     = smp_q;
    if (bus.in_valid) begin
      bin_d     = cnt;
      bub_d     = bubble;
      bin_vld_d = 1'b1;
      if (frame_last) begin
        sum_d     = acc_q + SW'(cnt);
        sum_vld_d = 1'b1;
        acc_d     = '0;
        smp_d     = '0;
      end else begin
        acc_d = acc_q + SW'(cnt);
        smp_d = smp_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q     <= '0;
      bub_q     <= 1'b0;
      bin_vld_q <= 1'b0;
      sum_q     <= '0;
      sum_vld_q <= 1'b0;
      acc_q     <= '0;
      smp_q     <= '0;
    end else begin
      bin_q     <= bin_d;
      bub_q     <= bub_d;
      bin_vld_q <= bin_vld_d;
      sum_q     <= sum_d;
      sum_vld_q <= sum_vld_d;
      acc_q     <= acc_d;
      smp_q     <= smp_d;
    end
  end

  assign bus.bin_out    = bin_q;
  assign bus.bubble_err = bub_q;
  assign bus.bin_valid  = bin_vld_q;
  assign bus.sum_out    = sum_q;
  assign bus.sum_valid  = sum_vld_q;
endmodule

// File: tb/tb_thermo_to_bin.sv
// Self-checking bench: directed and random samples compared against a frame-list reference model.
module tb_thermo_to_bin;
  import thermo_to_bin_pkg::*;

  localparam int OSF     = 8;
  localparam int SAMPLES = 128;

  logic clk = 1'b0;
  logic rst;

  thermo_to_bin_if #(.OSF(OSF), .SAMPLES(SAMPLES)) tb_if ();

  thermo_to_bin #(.SAMPLES(SAMPLES), .OSF(OSF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (tb_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int fails  = 0;
  int sum_pulses = 0;

  int exp_bin;
  bit exp_bub;
  bit exp_binv;
  int exp_sum;
  bit exp_sumv;
  int frame_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ctx);
    check({ctx, ".bin_valid"},  32'(tb_if.bin_valid),  32'(exp_binv));
    check({ctx, ".bin_out"},    32'(tb_if.bin_out),    32'(exp_bin));
    check({ctx, ".bubble_err"}, 32'(tb_if.bubble_err), 32'(exp_bub));
    check({ctx, ".sum_valid"},  32'(tb_if.sum_valid),  32'(exp_sumv));
    check({ctx, ".sum_out"},    32'(tb_if.sum_out),    32'(exp_sum));
  endtask

  task automatic model_reset();
    exp_bin  = 0;
    exp_bub  = 1'b0;
    exp_binv = 1'b0;
    exp_sum  = 0;
    exp_sumv = 1'b0;
    frame_q.delete();
  endtask

  // Drive one cycle, then check one cycle after the accepting edge.
  task automatic step(input string ctx, input bit v, input logic [OSF-1:0] d);
    int c;
    @(negedge clk);
    tb_if.in_valid  = v;
    tb_if.thermo_in = d;
    @(posedge clk);
    exp_binv = v;
    exp_sumv = 1'b0;
    if (v) begin
      c       = $countones(d);
      exp_bin = c;
      exp_bub = (d != OSF'((1 << c) - 1));
      frame_q.push_back(c);
      if (frame_q.size() == SAMPLES) begin
        exp_sum  = frame_q.sum();
        exp_sumv = 1'b1;
        frame_q.delete();
      end
    end
    #1;
    if (tb_if.sum_valid === 1'b1) sum_pulses++;
    check_all(ctx);
  endtask

  task automatic do_reset(input string ctx);
    @(negedge clk);
    rst            = 1'b1;
    tb_if.in_valid = 1'b0;
    #1;
    model_reset();
    check_all(ctx);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [OSF-1:0] dir_q[$];
    logic [OSF-1:0] d;
    int k;

    rst             = 1'b0;
    tb_if.in_valid  = 1'b0;
    tb_if.thermo_in = '0;
    #1 rst = 1'b1;
    #1;
    model_reset();
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    // Clean codes, back to back.
    dir_q = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'hFF};
    foreach (dir_q[i]) step("clean", 1'b1, dir_q[i]);

    // Bubbled codes followed by a clean one.
    dir_q = '{8'h02, 8'h04, 8'h57, 8'h1F};
    foreach (dir_q[i]) step("bubble", 1'b1, dir_q[i]);

    for (int i = 0; i < 5; i++) step("idle", 1'b0, OSF'($urandom));

    // Full 0F frame with an idle gap mid-frame; exactly one sum pulse expected.
    do_reset("rst_a");
    sum_pulses = 0;
    for (int i = 0; i < SAMPLES; i++) begin
      step("f0f", 1'b1, 8'h0F);
      if (i == 63) for (int j = 0; j < 4; j++) step("f0f_gap", 1'b0, OSF'($urandom));
    end
    check("f0f.pulses", 32'(sum_pulses), 32'd1);
    check("f0f.sum", 32'(tb_if.sum_out), 32'd512);

    for (int i = 0; i < SAMPLES; i++) step("fff", 1'b1, 8'hFF);
    check("fff.sum", 32'(tb_if.sum_out), 32'd1024);

    // Partial frame is discarded by reset.
    for (int i = 0; i < 50; i++) step("pre", 1'b1, 8'hFF);
    do_reset("rst_b");
    for (int i = 0; i < SAMPLES; i++) step("f01", 1'b1, 8'h01);
    check("f01.sum", 32'(tb_if.sum_out), 32'd128);

    // Random mix of clean and arbitrary codes with random gaps.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        k = $urandom_range(0, OSF);
        d = OSF'((1 << k) - 1);
      end else begin
        d = OSF'($urandom);
      end
      step("rand", $urandom_range(0, 3) != 0, d);
    end

    // Reset asserted between edges must clear outputs without waiting for a clock.
    step("pre_async", 1'b1, 8'hFF);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    rst            = 1'b0;
    tb_if.in_valid = 1'b0;
    step("post_async", 1'b1, 8'h07);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
